// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: request/grant/response bus handshake,
// lane steering, load extension, pipeline stall and fault reporting.
`timescale 1ns/1ps

module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_mode,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] MODE_BYTE      = 2'b00;
  localparam logic [1:0] MODE_HALF      = 2'b01;
  localparam logic [1:0] MODE_WORD      = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL   = 2'b11;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           mode_q;
  logic [1:0]           lane_q;
  logic                 uns_q;
  logic                 we_q;

  logic        req_c;
  logic        illegal_c;
  logic        misalign_c;
  logic        accept_c;
  logic        reject_c;
  logic        timeout_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted_c;
  logic [31:0] load_c;

  // Request classification; the cycle carrying a fault pulse never accepts.
  always_comb begin
    req_c      = mem_read | mem_write;
    illegal_c  = (mem_read & mem_write) | (mem_mode == MODE_ILLEGAL);
    misalign_c = ((mem_mode == MODE_HALF) & addr[0]) |
                 ((mem_mode == MODE_WORD) & (addr[1:0] != 2'b00));
    accept_c   = (state == S_IDLE) & req_c & ~fault & ~illegal_c & ~misalign_c;
    reject_c   = (state == S_IDLE) & req_c & ~fault & (illegal_c | misalign_c);
    timeout_c  = TIMEOUT_EN & (cnt == CNT_LAST);
  end

  assign stall = accept_c | (state == S_REQ) | (state == S_WAIT_R);

  // Byte enables and replicated store data for the addressed lanes.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (mem_mode)
      MODE_BYTE: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      MODE_HALF: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    shifted_c = bus_rdata >> {lane_q, 3'b000};
    case (mode_q)
      MODE_BYTE: load_c = {{24{~uns_q & shifted_c[7]}}, shifted_c[7:0]};
      MODE_HALF: load_c = {{16{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
      default:   load_c = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mode_q      <= MODE_BYTE;
      lane_q      <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= 4'b0000;
      bus_wdata   <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (reject_c) begin
            fault       <= 1'b1;
            fault_cause <= illegal_c ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          end else if (accept_c) begin
            mode_q    <= mem_mode;
            lane_q    <= addr[1:0];
            uns_q     <= mem_unsigned;
            we_q      <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            bus_we    <= mem_write;
            bus_req   <= 1'b1;
            cnt       <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          cnt <= cnt + CNT_WIDTH'(1);
          // A store completes on grant; a read grant alone is not a completion.
          if (bus_gnt && we_q) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (timeout_c) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= S_IDLE;
          end else if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (bus_rvalid) begin
            rdata <= load_c;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (timeout_c) begin
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, hand-written corner
// sequences and randomized accesses against an arithmetic reference model.
`timescale 1ns/1ps

module tb_dmem_access_ctrl;

  localparam int T  = 4;
  localparam int NV = 15;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_mode;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_mode(mem_mode),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done), .fault(fault),
    .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  mode;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rword;
    int          g;        // REQ cycles before grant
    int          r;        // WAIT_R cycles before rvalid
    logic [1:0]  cause;    // 0 = completes
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rdv;
    int          stall_n;
    int          req_n;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rdata = '0;
  vec_t        vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one access from the access rules alone.
  function automatic vec_t model(input logic rd, input logic wr, input logic [1:0] mode,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rword, input int g, input int r);
    vec_t   v;
    int     size, off, busy;
    longint x;
    v = '{rd, wr, mode, uns, a, wd, rword, g, r, 2'd0, 4'd0, 32'd0, last_rdata, 0, 0};
    size = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      v.be[i] = (i >= off) && (i < off + size);
      v.bwd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    x = {32'd0, rword};
    x = (x >> (8 * off)) & ((64'sd1 << (8 * size)) - 1);
    if (size < 4 && !uns && x >= (64'sd1 << (8 * size - 1)))
      x = x - (64'sd1 << (8 * size));
    busy = wr ? g + 1 : g + r + 2;
    if ((rd && wr) || mode == 2'd3) v.cause = 2'd3;
    else if (off % size != 0) v.cause = 2'd1;
    else begin
      v.stall_n = 1 + ((busy > T) ? T : busy);
      v.req_n   = (g + 1 > T) ? T : g + 1;
      if (busy > T) v.cause = 2'd2;
      else if (rd) v.rdv = 32'(x);
    end
    return v;
  endfunction

  // Drives one access from IDLE and acts as the bus slave; returns at posedge+1.
  task automatic run_access(input vec_t v, input bit noise);
    int stall_n = 0, req_n = 0, phase = 0, pc = 0;
    bit ended = 0, seen_req = 0;
    mem_read = v.rd; mem_write = v.wr; mem_mode = v.mode;
    mem_unsigned = v.uns; addr = v.a; wdata = v.wd;
    if (v.cause == 2'd1 || v.cause == 2'd3) begin
      @(negedge clk);
      chk("reject_stall", 32'(stall), 32'd0);
      chk("reject_bus_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk("reject_fault", 32'({fault, done, stall, bus_req}), 32'b1000);
      chk("reject_cause", 32'(fault_cause), 32'(v.cause));
      chk("reject_rdata_held", rdata, last_rdata);
      @(posedge clk); #1;
      return;
    end
    for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (cyc > 0) begin
        if (phase == 0) begin
          if (pc == v.g) bus_gnt = 1'b1;
          if (noise) bus_rvalid = 1'($urandom % 2);
        end else if (phase == 1 && pc == v.r) begin
          bus_rvalid = 1'b1;
          bus_rdata  = v.rword;
        end
      end
      @(negedge clk);
      if (stall) begin
        stall_n++;
        if (done || fault) chk("early_done_fault", 32'({done, fault}), 32'd0);
        if (bus_req) begin
          req_n++;
          if (!seen_req) begin
            seen_req = 1;
            chk("bus_addr", bus_addr, v.a & 32'hFFFF_FFFC);
            chk("bus_be", 32'(bus_be), 32'(v.be));
            chk("bus_we", 32'(bus_we), 32'(v.wr));
            if (v.wr) chk("bus_wdata", bus_wdata, v.bwd);
          end
        end
      end else begin
        ended = 1;
        if (v.cause == 2'd2) begin
          chk("timeout_fault", 32'({fault, done}), 32'b10);
          chk("timeout_cause", 32'(fault_cause), 32'd2);
          chk("timeout_rdata_held", rdata, last_rdata);
        end else begin
          chk("done_pulse", 32'({fault, done}), 32'b01);
          chk("rdata", rdata, v.rd ? v.rdv : last_rdata);
        end
      end
      if (cyc > 0) begin
        if (phase == 0 && bus_gnt) begin phase = v.wr ? 2 : 1; pc = 0; end
        else if (phase == 1 && bus_rvalid) begin phase = 2; pc = 0; end
        else pc++;
      end
      @(posedge clk); #1;
    end
    if (!ended) chk("access_cycle_bound", 32'd0, 32'd1);
    chk("stall_cycles", 32'(stall_n), 32'(v.stall_n));
    chk("bus_req_cycles", 32'(req_n), 32'(v.req_n));
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    if (v.cause == 2'd0 && v.rd) last_rdata = v.rdv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    logic [1:0] m;
    int kind;
    logic [31:0] ra;

    //          rd    wr    mode  uns   addr           wdata          rword          g  r  cause be       bwd            rdv            st rq
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,         32'h8012_3456, 1, 1, 2'd0, 4'b1000, 32'h0,         32'hFFFF_FF80, 5, 2};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 0, 0, 2'd0, 4'b1100, 32'h0,         32'h0000_BEEF, 3, 1};
    vecs[2]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 0, 0, 2'd0, 4'b1100, 32'h0,         32'hFFFF_BEEF, 3, 1};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 0, 2'd0, 4'b0010, 32'hA5A5_A5A5, 32'h0,         2, 1};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         0, 0, 2'd1, 4'b0000, 32'h0,         32'h0,         0, 0};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 2'd3, 4'b0000, 32'h0,         32'h0,         0, 0};
    vecs[6]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 2'd3, 4'b0000, 32'h0,         32'h0,         0, 0};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h1234,      32'h0,         0, 0, 2'd1, 4'b0000, 32'h0,         32'h0,         0, 0};
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 2'd3, 4'b0000, 32'h0,         32'h0,         0, 0};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,         2, 0, 2'd0, 4'b1111, 32'h1234_5678, 32'h0,         4, 3};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_00FF, 0, 2, 2'd0, 4'b0001, 32'h0,         32'h0000_00FF, 5, 1};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'hABCD_CAFE, 32'h0,         1, 0, 2'd0, 4'b1100, 32'hCAFE_CAFE, 32'h0,         3, 2};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h0000_0001, 32'h0,         9, 0, 2'd2, 4'b1111, 32'h0000_0001, 32'h0,         5, 4};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0,         32'h00FF_0000, 0, 0, 2'd0, 4'b0100, 32'h0,         32'hFFFF_FFFF, 3, 1};
    vecs[14] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0,         32'h1111_2222, 1, 2, 2'd2, 4'b1111, 32'h0,         32'h0,         5, 2};

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_mode = 2'd0;
    mem_unsigned = 1'b0; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({stall, done, fault, bus_req, bus_we, fault_cause}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_bus", bus_addr | bus_wdata | 32'(bus_be), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_access(vecs[i], 1'b0);

    // Stray response after a read timeout must be ignored.
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rvalid_rdata", rdata, last_rdata);
    chk("late_rvalid_ctrl", 32'({done, fault, stall}), 32'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_after", rdata, last_rdata);
    chk("late_rvalid_done", 32'(done), 32'd0);
    @(posedge clk); #1;

    // Randomized accesses against the model, with stray rvalid in REQ.
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom % 10);
      m = ($urandom % 8 == 7) ? 2'd3 : 2'($urandom % 3);
      ra = $urandom;
      if ($urandom % 4 != 0) begin
        if (m == 2'd1) ra[0] = 1'b0;
        if (m == 2'd2) ra[1:0] = 2'b00;
      end
      rv = model(kind <= 5 ? 1'b1 : 1'b0, (kind == 0 || kind > 5) ? 1'b1 : 1'b0,
                 m, 1'($urandom % 2), ra, $urandom, $urandom,
                 int'($urandom % 4), int'($urandom % 3));
      run_access(rv, 1'b1);
    end

    // Reset in WAIT_R abandons the load; a store afterwards runs normally.
    mem_read = 1'b1; mem_write = 1'b0; mem_mode = 2'd2; addr = 32'h20;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("wait_r_stall", 32'({stall, bus_req}), 32'b10);
    #2;
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("async_reset_ctrl", 32'({stall, done, fault, bus_req, bus_we, fault_cause}), 32'd0);
    chk("async_reset_rdata", rdata, 32'd0);
    chk("async_reset_bus", bus_addr | bus_wdata | 32'(bus_be), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rdata = '0;
    @(posedge clk); #1;
    run_access(model(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h0, 0, 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the RV32I pipeline.
- Takes the decoder's DMEM read/write strobes, the access width mode and the unsigned flag (funct3[2]), together with the ALU-computed address and rs2 data.
- Runs a request/grant/response handshake on the data bus and stalls the pipeline until the access completes.
- Generates byte enables and write-lane steering, sign/zero-extends load data, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT_R before a timeout fault; 0 disables the timeout.
- CNT_WIDTH, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_read  input  1  load request from decoder pipeline register
- mem_write  input  1  store request from decoder pipeline register
- mem_mode  input  2  access width: 00 byte, 01 halfword, 10 word, 11 illegal
- mem_unsigned  input  1  zero-extend load data (LBU/LHU)
- addr  input  32  byte address from ALU
- wdata  input  32  store data (rs2), right-aligned
- stall  output  1  freeze pipeline stages up to and including MEM
- rdata  output  32  extended load result, valid while done=1, held afterwards
- done  output  1  one-cycle pulse when the access completes
- fault  output  1  one-cycle pulse when the access is aborted
- fault_cause  output  2  01 misaligned, 10 timeout, 11 illegal (mode 11 or read+write together); held until the next fault
- bus_req  output  1  bus request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-steered store data
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  raw word read data

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; stall, done, fault, bus_req, bus_we = 0; fault_cause, rdata, bus_addr, bus_be, bus_wdata = 0; counter = 0. A reset mid-transaction abandons it, and bus_req drops immediately.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE, request seen (mem_read|mem_write):
  - Read and write together, mode 11, or misalignment (half with addr[0]=1; word with addr[1:0]!=0): pulse fault next cycle with the matching cause. No bus activity. Stay IDLE. Priority illegal > misaligned.
  - Otherwise latch addr, mode, unsigned, we and steered data/enables, then go to REQ.
  - stall is combinational: 1 in IDLE during the accept cycle, and 1 throughout REQ and WAIT_R. It is 0 in DONE and in the fault-pulse cycle.
- Steering, from latched addr[1:0] = a:
  - byte: be = 1<<a; wdata = {4{wdata[7:0]}}.
  - half: be = 0011 (a=0) or 1100 (a=2); wdata = {2{wdata[15:0]}}.
  - word: be = 1111.
  - bus_be and bus_wdata are registered and stable for the whole REQ state.
- REQ: bus_req=1.
  - On bus_gnt for a write: go to DONE.
  - On bus_gnt for a read: go to WAIT_R. bus_req deasserts the cycle after gnt.
- WAIT_R: on bus_rvalid, extract the lane and extend, register into rdata, go to DONE.
  - Extraction: byte = bus_rdata[8a+:8]; half = bus_rdata[8a+:16]; sign-extend unless unsigned; word passes through.
  - bus_rvalid is ignored in every state except WAIT_R; a stray late response after a timeout has no effect.
  - bus_rvalid asserted in the same cycle as bus_gnt is not a legal bus response and is ignored.
- DONE: done=1 for exactly one cycle, stall=0, then return to IDLE. A request present in the following IDLE cycle belongs to the next instruction and is accepted normally, giving back-to-back accesses with one idle/accept cycle.
- Timeout:
  - The counter clears on entering REQ and increments every cycle in REQ/WAIT_R.
  - When count == TIMEOUT_CYCLES-1 without completion: drop bus_req, pulse fault with cause 10, return to IDLE, stall=0.
  - A completion in the same cycle as the timeout wins.
- Minimum latency: store 2 cycles of stall (accept, gnt); load 3+ cycles.

Test Plan:
- LB: addr=0x103, bus_rdata=0x80xxxxxx, gnt after 1 cycle, rvalid 2 cycles later -> bus_be=1000, bus_addr=0x100, rdata=0xFFFFFF80, done pulses once, stall high until DONE.
- LHU: addr=0x202, bus_rdata=0xBEEF1234 -> bus_be=1100, rdata=0x0000BEEF; the same access as LH gives 0xFFFFBEEF.
- SB: addr=0x1, wdata=0x000000A5, immediate gnt -> bus_we=1, bus_be=0010, bus_wdata=0xA5A5A5A5, total stall 2 cycles.
- Misaligned LW: addr=0x6 -> no bus_req, fault=1 with cause 01 for one cycle, stall 0. Read+write together -> cause 11.
- Timeout with TIMEOUT_CYCLES=4 and gnt never asserted -> bus_req high for 4 cycles then drops, fault cause 10. A late rvalid afterwards leaves rdata unchanged.
- Reset asserted in WAIT_R -> outputs zero asynchronously. After release, a new SW at 0x10 completes normally with be=1111.
